// File: rtl/vram_arb_pkg.sv
// Shared constants and FSM state type for the VRAM arbiter.
// Optional build macro used by vram_arbiter: VRAM_ARB_STATS_EN.
package vram_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 17;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned FB_WIDTH   = 320;
  localparam int unsigned FB_HEIGHT  = 240;
  localparam int unsigned VID_ADDR_W = 17;
  localparam int unsigned STAT_W     = 16;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/vram_addr_gen.sv
// Framebuffer address from screen coordinates: (y>>1)*320 + (x>>1).
// 320 = 256 + 64, so the product is built from two shifts and an add.
module vram_addr_gen
  import vram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic [9:0]        xpos,
  input  logic [9:0]        ypos,
  output logic [ADDR_W-1:0] vid_addr
);

  logic [8:0]            fb_x;
  logic [8:0]            fb_y;
  logic [VID_ADDR_W-1:0] sum;
  logic                  unused_lsb;

  assign fb_x       = xpos[9:1];
  assign fb_y       = ypos[9:1];
  // Pixel doubling: the coordinate LSBs do not select a framebuffer byte.
  assign unused_lsb = xpos[0] ^ ypos[0];

  // y*256 + y*64 + x
  assign sum = (VID_ADDR_W'(fb_y) << 8) + (VID_ADDR_W'(fb_y) << 6) + VID_ADDR_W'(fb_x);

  assign vid_addr = ADDR_W'(sum);

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video scan-out reads have absolute priority,
// CPU accesses fill the remaining cycles through a two-state IDLE/ACK FSM.
// Build macro VRAM_ARB_STATS_EN adds a saturating CPU stall counter.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              CLK_50M,
  input  logic              reset,
  input  logic              pix_ce,
  input  logic              vid_active,
  input  logic [9:0]        xpos,
  input  logic [9:0]        ypos,
  output logic [DATA_W-1:0] vid_pixel,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [STAT_W-1:0] cpu_stall_cnt
);

  arb_state_e        state_q;
  logic              rd_q;
  logic              vid_slot_q;
  logic              blank_ce_q;
  logic [DATA_W-1:0] vid_pixel_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [ADDR_W-1:0] vid_addr;
  logic              video_slot_c;
  logic              cpu_issue_c;

  vram_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .xpos     (xpos),
    .ypos     (ypos),
    .vid_addr (vid_addr)
  );

  assign video_slot_c = pix_ce & vid_active;
  // A CPU access goes out only from IDLE, outside video slots, and never under reset.
  assign cpu_issue_c  = (state_q == IDLE) & cpu_req & ~video_slot_c & ~reset;

  // RAM port mux: video first, then CPU, otherwise parked at address 0.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (video_slot_c) begin
      mem_addr = vid_addr;
    end else if (cpu_issue_c) begin
      mem_addr  = cpu_addr;
      mem_we    = cpu_we;
      mem_wdata = cpu_wdata;
    end
  end

  // Arbiter FSM plus pixel and read-data capture one cycle after each RAM access.
  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      state_q     <= IDLE;
      rd_q        <= 1'b0;
      vid_slot_q  <= 1'b0;
      blank_ce_q  <= 1'b0;
      vid_pixel_q <= '0;
      cpu_rdata_q <= '0;
    end else begin
      vid_slot_q <= video_slot_c;
      blank_ce_q <= pix_ce & ~vid_active;
      if (vid_slot_q) begin
        vid_pixel_q <= mem_rdata;
      end else if (blank_ce_q) begin
        vid_pixel_q <= '0;
      end
      case (state_q)
        IDLE: begin
          if (cpu_issue_c) begin
            state_q <= ACK;
            rd_q    <= ~cpu_we;
          end
        end
        ACK: begin
          state_q <= IDLE;
          if (rd_q) begin
            cpu_rdata_q <= mem_rdata;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vid_pixel = vid_pixel_q;
  assign cpu_rdata = cpu_rdata_q;
  // A reset landing in the ACK cycle suppresses the acknowledge of the abandoned access.
  assign cpu_ack   = (state_q == ACK) & ~reset;

`ifdef VRAM_ARB_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q;

  // Count IDLE cycles in which a pending CPU request was held off; saturates.
  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if ((state_q == IDLE) && cpu_req && !cpu_issue_c && (stall_cnt_q != {STAT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + STAT_W'(1);
    end
  end

  assign cpu_stall_cnt = stall_cnt_q;
`else
  assign cpu_stall_cnt = '0;
`endif

endmodule
